// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared definitions for the iterative DES core.
//   - FSM state encoding
//   - DES permutation tables IP, FP, E, P, PC1 and PC2. Entries are 1-based
//     DES bit numbers, and DES bit 1 is the MSB of the vector.
//   - per-round key rotation amounts for encryption and decryption
//   - the eight S-boxes
//   - permutation, rotation and S-box helper functions
// ---------------------------------------------------------------------------
package des_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned FP_TAB [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    localparam int unsigned E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Parity bits 8, 16, ..., 64 never appear here, so they are dropped.
    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left rotation applied before encryption round i (index i-1).
    localparam int unsigned SHIFT [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Right rotation applied before decryption round i. The first round
    // uses the unrotated C||D because K16 = PC2(C0||D0).
    localparam int unsigned RSHIFT [16] = '{
        0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    localparam int unsigned SBOX [8][4][16] = '{
        '{ '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7},
           '{ 0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8},
           '{ 4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0},
           '{15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13} },
        '{ '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10},
           '{ 3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5},
           '{ 0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15},
           '{13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9} },
        '{ '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8},
           '{13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1},
           '{13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7},
           '{ 1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12} },
        '{ '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15},
           '{13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9},
           '{10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4},
           '{ 3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14} },
        '{ '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9},
           '{14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6},
           '{ 4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14},
           '{11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3} },
        '{ '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11},
           '{10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8},
           '{ 9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6},
           '{ 4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13} },
        '{ '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1},
           '{13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6},
           '{ 1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2},
           '{ 6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12} },
        '{ '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7},
           '{ 1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2},
           '{ 7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8},
           '{ 2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11} }
    };

    // Output bit k (DES numbering) takes input bit TAB[k-1]. Because DES
    // bit 1 is the MSB, DES bit n of a W-bit vector sits at index W-n.
    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TAB[6'(i)])];
        return y;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TAB[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TAB[6'(i)])];
        return y;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TAB[5'(i)])];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TAB[6'(i)])];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TAB[6'(i)])];
        return y;
    endfunction

    // Row comes from the outer bits b1,b6, column from b2..b5.
    function automatic logic [3:0] des_sbox(input logic [2:0] box, input logic [5:0] b);
        return 4'(SBOX[box][{b[5], b[0]}][b[4:1]]);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input int unsigned n);
        case (n)
            1:       return {x[26:0], x[27]};
            2:       return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input int unsigned n);
        case (n)
            1:       return {x[0], x[27:1]};
            2:       return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_round.sv
// ---------------------------------------------------------------------------
// des_round
// One combinational DES round. It advances the key schedule and performs
// the Feistel step.
// Ports:
//   l_i, r_i   [31:0]  block halves entering the round
//   c_i, d_i   [27:0]  key-schedule halves entering the round
//   decrypt_i          1 = rotate right (K16..K1), 0 = rotate left (K1..K16)
//   rnd_i      [3:0]   zero-based round index (round i uses index i-1)
//   l_o, r_o   [31:0]  block halves after the round (L' = R, R' = L ^ f)
//   c_o, d_o   [27:0]  rotated key-schedule halves for the next round
// ---------------------------------------------------------------------------
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l_i,
    input  logic [31:0] r_i,
    input  logic [27:0] c_i,
    input  logic [27:0] d_i,
    input  logic        decrypt_i,
    input  logic [3:0]  rnd_i,
    output logic [31:0] l_o,
    output logic [31:0] r_o,
    output logic [27:0] c_o,
    output logic [27:0] d_o
);

    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic [47:0] subkey;
    logic [47:0] e_x;
    logic [31:0] s_out;

    // The key halves are rotated before the subkey is taken, so the rotated
    // value is also what the next round starts from.
    always_comb begin
        c_rot = c_i;
        d_rot = d_i;
        if (decrypt_i) begin
            c_rot = rotr28(c_i, RSHIFT[rnd_i]);
            d_rot = rotr28(d_i, RSHIFT[rnd_i]);
        end else begin
            c_rot = rotl28(c_i, SHIFT[rnd_i]);
            d_rot = rotl28(d_i, SHIFT[rnd_i]);
        end
    end

    assign subkey = des_pc2({c_rot, d_rot});
    assign e_x    = des_e(r_i) ^ subkey;

    // S-box j (0-based) reads DES bits 6j+1..6j+6 and writes DES bits
    // 4j+1..4j+4.
    always_comb begin
        s_out = '0;
        for (int j = 0; j < 8; j++) begin
            s_out[5'(28 - 4 * j) +: 4] = des_sbox(3'(j), e_x[6'(42 - 6 * j) +: 6]);
        end
    end

    assign l_o = r_i;
    assign r_o = l_i ^ des_p(s_out);
    assign c_o = c_rot;
    assign d_o = d_rot;

endmodule

// File: rtl/des_iter_core.sv
// ---------------------------------------------------------------------------
// des_iter_core
// Iterative DES engine. It processes one block at a time and runs
// ROUNDS_PER_CYCLE rounds per clock, so it needs 16/ROUNDS_PER_CYCLE RUN
// cycles per block.
// Parameter:
//   ROUNDS_PER_CYCLE  rounds unrolled per clock: 1, 2, 4, 8 or 16
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   in_valid     block/key/mode valid
//   in_ready     core idle and able to take a block
//   plainText    64-bit input block, DES bit 1 = [63]
//   key          64-bit DES key (parity bits ignored)
//   decrypt      0 = encrypt, 1 = decrypt, sampled with the block
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts the result
//   encrypted    64-bit result block, DES bit 1 = [63]
// ---------------------------------------------------------------------------
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] plainText,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] encrypted
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
              ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
            $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [4:0] RND_STEP = 5'(ROUNDS_PER_CYCLE);

    state_e      state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [63:0] enc_q, enc_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic        dec_q, dec_d;

    logic [63:0] ip_blk;
    logic [55:0] pc1_key;

    // Element g feeds round copy g. Element ROUNDS_PER_CYCLE is the state
    // after this cycle's last round.
    logic [ROUNDS_PER_CYCLE:0][31:0] l_c;
    logic [ROUNDS_PER_CYCLE:0][31:0] r_c;
    logic [ROUNDS_PER_CYCLE:0][27:0] c_c;
    logic [ROUNDS_PER_CYCLE:0][27:0] d_c;

    assign ip_blk  = des_ip(plainText);
    assign pc1_key = des_pc1(key);

    assign l_c[0] = l_q;
    assign r_c[0] = r_q;
    assign c_c[0] = c_q;
    assign d_c[0] = d_q;

    // rnd_q is a multiple of ROUNDS_PER_CYCLE while running, so the round
    // index of each copy stays within 0..15.
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        des_round u_round (
            .l_i       (l_c[g]),
            .r_i       (r_c[g]),
            .c_i       (c_c[g]),
            .d_i       (d_c[g]),
            .decrypt_i (dec_q),
            .rnd_i     (rnd_q[3:0] + 4'(g)),
            .l_o       (l_c[g+1]),
            .r_o       (r_c[g+1]),
            .c_o       (c_c[g+1]),
            .d_o       (d_c[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        enc_d   = enc_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = ip_blk[63:32];
                    r_d     = ip_blk[31:0];
                    c_d     = pc1_key[55:28];
                    d_d     = pc1_key[27:0];
                    dec_d   = decrypt;
                    rnd_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                l_d   = l_c[ROUNDS_PER_CYCLE];
                r_d   = r_c[ROUNDS_PER_CYCLE];
                c_d   = c_c[ROUNDS_PER_CYCLE];
                d_d   = d_c[ROUNDS_PER_CYCLE];
                rnd_d = rnd_q + RND_STEP;
                // The halves are swapped before FP, undoing the last round's swap.
                if (rnd_d == 5'd16) begin
                    enc_d   = des_fp({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---- control and result register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            enc_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            enc_q   <= enc_d;
        end
    end

    // ---- working datapath register boundary (only read while RUN) ----
    always_ff @(posedge clk) begin
        l_q   <= l_d;
        r_q   <= r_d;
        c_q   <= c_d;
        d_q   <= d_d;
        dec_q <= dec_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign encrypted = enc_q;

endmodule

// File: tb/tb_des_iter_core.sv
// ---------------------------------------------------------------------------
// tb_des_iter_core
// Directed bench for des_iter_core. One instance is built for each legal
// ROUNDS_PER_CYCLE. Instance k uses RPC = 1 << k.
// ---------------------------------------------------------------------------
module tb_des_iter_core;

    localparam int NI = 5;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C2 = 64'h0000000000000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [NI];
    logic        ir   [NI];
    logic        ov   [NI];
    logic        ordy [NI];
    logic        dcr  [NI];
    logic [63:0] pt   [NI];
    logic [63:0] ky   [NI];
    logic [63:0] enc  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .plainText (pt[g]),
            .key       (ky[g]),
            .decrypt   (dcr[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .encrypted (enc[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(input int k, input string tag);
        int t = 0;
        while (!ir[k] && t < 60) begin
            step();
            t++;
        end
        check({tag, "/ready"}, 64'(ir[k]), 64'd1);
    endtask

    // Accept one block on instance k, check latency and result, hold the
    // result under backpressure for 'hold' cycles, then release it.
    task automatic run_block(input int k, input logic [63:0] kk, input logic [63:0] p,
                             input logic d, input logic [63:0] exp, input int hold,
                             input bit churn, input string tag);
        int t = 0;
        wait_ready(k, tag);
        iv[k] = 1'b1; pt[k] = p; ky[k] = kk; dcr[k] = d;
        step();
        iv[k] = 1'b0;
        check({tag, "/busy"}, 64'({ir[k], ov[k]}), 64'b00);
        while (!ov[k] && t < 60) begin
            if (churn) begin
                pt[k] = {$urandom, $urandom}; ky[k] = {$urandom, $urandom};
                dcr[k] = 1'($urandom); iv[k] = 1'($urandom);
            end
            step();
            t++;
        end
        iv[k] = 1'b0;
        check({tag, "/latency"}, 64'(t), 64'(16 >> k));
        check({tag, "/result"}, enc[k], exp);
        for (int h = 0; h < hold; h++) begin
            if (churn) begin
                pt[k] = {$urandom, $urandom}; ky[k] = {$urandom, $urandom};
                dcr[k] = 1'($urandom);
            end
            step();
            check({tag, "/hold_data"}, enc[k], exp);
            check({tag, "/hold_flags"}, 64'({ir[k], ov[k]}), 64'b01);
        end
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
        check({tag, "/release"}, 64'({ir[k], ov[k]}), 64'b10);
    endtask

    // in_valid and out_ready are held high. Each block takes the accept
    // edge, 16/RPC round edges and one DONE edge, and then an IDLE cycle
    // passes before the next accept edge.
    task automatic back_to_back(input int k, input string tag);
        int acc [3] = '{0, 0, 0};
        int n = 0;
        int cyc = 0;
        ordy[k] = 1'b1; iv[k] = 1'b1; pt[k] = P1; ky[k] = K1; dcr[k] = 1'b0;
        while (n < 3 && cyc < 200) begin
            if (ir[k]) begin
                acc[n] = cyc;
                n++;
            end
            if (ov[k]) check({tag, "/result"}, enc[k], C1);
            step();
            cyc++;
        end
        iv[k] = 1'b0;
        check({tag, "/accepts"}, 64'(n), 64'd3);
        check({tag, "/interval1"}, 64'(acc[1] - acc[0]), 64'((16 >> k) + 2));
        check({tag, "/interval2"}, 64'(acc[2] - acc[1]), 64'((16 >> k) + 2));
        wait_ready(k, {tag, "/drain"});
        ordy[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; dcr[k] = 1'b0;
            pt[k] = '0; ky[k] = '0;
        end
        @(negedge clk);
        step();
        step();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset%0d/in_ready", k), 64'(ir[k]), 64'd1);
            check($sformatf("reset%0d/out_valid", k), 64'(ov[k]), 64'd0);
            check($sformatf("reset%0d/encrypted", k), enc[k], 64'd0);
        end
        rst = 1'b0;
        step();

        // Known-answer encryption on every unroll factor.
        for (int k = 0; k < NI; k++) begin
            run_block(k, K1, P1, 1'b0, C1, 0, 1'b0, $sformatf("kat1_rpc%0d", 1 << k));
        end

        // Decrypt, with a 10-cycle output stall.
        run_block(0, K1, C1, 1'b1, P1, 10, 1'b0, "dec1_bp");
        run_block(0, K2, P2, 1'b0, C2, 0, 1'b0, "kat2_enc");
        run_block(0, K2, C2, 1'b1, P2, 0, 1'b0, "kat2_dec");
        run_block(4, K2, C2, 1'b1, P2, 0, 1'b0, "kat2_dec_rpc16");
        run_block(2, K1, C1, 1'b1, P1, 0, 1'b0, "dec1_rpc4");

        // Reset after five rounds. enc[0] currently holds 8787... .
        wait_ready(0, "midrst");
        iv[0] = 1'b1; pt[0] = P1; ky[0] = K1; dcr[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst/out_valid", 64'(ov[0]), 64'd0);
        check("midrst/in_ready", 64'(ir[0]), 64'd1);
        check("midrst/encrypted", enc[0], 64'd0);
        run_block(0, K1, P1, 1'b0, C1, 0, 1'b0, "after_rst");

        // The inputs change every cycle while the core is busy.
        run_block(0, K2, P2, 1'b0, C2, 3, 1'b1, "churn_enc");
        run_block(1, K1, C1, 1'b1, P1, 2, 1'b1, "churn_dec");

        back_to_back(0, "b2b_rpc1");
        back_to_back(4, "b2b_rpc16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
